// File: rtl/psum_accum_ctrl_if.sv
// Beat/result handshake bundle between the adder tree, psum_accum_ctrl and the activation buffer.
// slave is the controller's view; master is the environment's view.
interface psum_accum_ctrl_if #(
   parameter int LANES = 8,
   parameter int IN_W  = 18,
   parameter int OUT_W = 4
);

   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*IN_W-1:0]    in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*OUT_W-1:0]   out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulator/requantizer behind the adder tree: sums num_pass beats per lane, then shifts and saturates.
// Optional macro PSUM_ACC_ROUND_EN selects round-half-up before the shift (default: truncate).
module psum_accum_ctrl #(
   parameter int LANES = 8,
   parameter int IN_W  = 18,
   parameter int ACC_W = 24,
   parameter int OUT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CNT_W-1:0]   num_pass,
   input  logic [4:0]         shift,
   psum_accum_ctrl_if.slave   bus,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

   state_t                  state;
   state_t                  state_nxt;

   logic [ACC_W-1:0]        acc       [LANES];
   logic [ACC_W:0]          acc_wide  [LANES];
   logic [ACC_W-1:0]        acc_sum   [LANES];
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        num_pass_q;
   logic [4:0]              shift_q;
   logic [LANES*OUT_W-1:0]  out_data_q;
   logic [LANES*OUT_W-1:0]  quant_data;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    busy_q;
   logic                    beat_acc;
   logic                    last_beat;
   logic                    job_start;

   // Right shift then clamp to OUT_W bits; shifts of ACC_W or more always give zero.
   function automatic logic [OUT_W-1:0] quantize(input logic [ACC_W-1:0] a,
                                                 input logic [4:0]       sh);
      logic [ACC_W-1:0] pre;
      logic [ACC_W-1:0] q_wide;
`ifdef PSUM_ACC_ROUND_EN
      logic [ACC_W:0]   rnd;
`endif
      pre = a;
`ifdef PSUM_ACC_ROUND_EN
      rnd = {1'b0, a} + ((ACC_W+1)'(1) << (sh - 5'd1));
      if ((sh != 5'd0) && (32'(sh) < ACC_W)) begin
         pre = rnd[ACC_W] ? '1 : rnd[ACC_W-1:0];
      end
`endif
      if (32'(sh) >= ACC_W) begin
         q_wide = '0;
      end else begin
         q_wide = pre >> sh;
      end
      if (q_wide > OUT_MAX) begin
         return '1;
      end
      return q_wide[OUT_W-1:0];
   endfunction

   assign job_start = (state == IDLE) && start;
   assign beat_acc  = in_ready_q && bus.in_valid;
   assign last_beat = (cnt == (num_pass_q - CNT_W'(1)));

   // Per-lane saturating add of the incoming beat; the carry out flags overflow.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         acc_wide[l] = {1'b0, acc[l]} + (ACC_W+1)'(bus.in_data[IN_W*l +: IN_W]);
         acc_sum[l]  = acc_wide[l][ACC_W] ? '1 : acc_wide[l][ACC_W-1:0];
      end
   end

   always_comb begin
      quant_data = '0;
      for (int l = 0; l < LANES; l++) begin
         quant_data[OUT_W*l +: OUT_W] = quantize(acc_sum[l], shift_q);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (beat_acc && last_beat) begin
               state_nxt = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_valid_q && bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Handshake flags are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         in_ready_q  <= (state_nxt == ACCUM);
         out_valid_q <= (state_nxt == OUTPUT);
         busy_q      <= (state_nxt != IDLE);
      end
   end

   // The result is captured from the same saturated sums that absorb the final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         num_pass_q <= '0;
         shift_q    <= '0;
         out_data_q <= '0;
         for (int l = 0; l < LANES; l++) begin
            acc[l] <= '0;
         end
      end else if (job_start) begin
         num_pass_q <= (num_pass == '0) ? CNT_W'(1) : num_pass;
         shift_q    <= shift;
         cnt        <= '0;
         for (int l = 0; l < LANES; l++) begin
            acc[l] <= '0;
         end
      end else if (beat_acc) begin
         cnt <= cnt + CNT_W'(1);
         for (int l = 0; l < LANES; l++) begin
            acc[l] <= acc_sum[l];
         end
         if (last_beat) begin
            out_data_q <= quant_data;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed self-checking bench for psum_accum_ctrl with hand-computed lane results.
module tb_psum_accum_ctrl;

   localparam int LANES = 8;
   localparam int IN_W  = 18;
   localparam int ACC_W = 24;
   localparam int OUT_W = 4;
   localparam int CNT_W = 8;

`ifdef PSUM_ACC_ROUND_EN
   localparam logic [31:0] T6_EXP = 32'h22222222;
`else
   localparam logic [31:0] T6_EXP = 32'h11111111;
`endif

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             start    = 1'b0;
   logic [CNT_W-1:0] num_pass = '0;
   logic [4:0]       shift    = '0;
   logic             busy;

   int num_checks = 0;
   int num_fails  = 0;

   psum_accum_ctrl_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   psum_accum_ctrl #(
      .LANES (LANES),
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .num_pass (num_pass),
      .shift    (shift),
      .bus      (bus),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LANES*IN_W-1:0] beat_all(input logic [IN_W-1:0] v);
      return {LANES{v}};
   endfunction

   function automatic logic [LANES*IN_W-1:0] beat3(input logic [IN_W-1:0] a0,
                                                   input logic [IN_W-1:0] a1,
                                                   input logic [IN_W-1:0] a2);
      return {{((LANES-3)*IN_W){1'b0}}, a2, a1, a0};
   endfunction

   task automatic startJob(input logic [CNT_W-1:0] np, input logic [4:0] sh);
      start    = 1'b1;
      num_pass = np;
      shift    = sh;
      tick();
      start    = 1'b0;
   endtask

   task automatic applyStimulus(input logic [LANES*IN_W-1:0] data);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   // Result must be present the cycle after the last beat, then handshake back to idle.
   task automatic finishJob(input string tag, input logic [31:0] exp);
      checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_data"}, bus.out_data, exp);
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checkOutput({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_out_data", bus.out_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // T1: single pass, no shift
      startJob(8'd1, 5'd0);
      checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      applyStimulus(beat_all(18'd3));
      finishJob("t1", 32'h33333333);

      // T2: three passes with a bubble; config inputs change after start
      startJob(8'd3, 5'd2);
      num_pass = 8'd1;
      shift    = 5'd0;
      applyStimulus(beat3(18'd10, 18'd7, 18'd30));
      checkOutput("t2_valid_early1", 32'(bus.out_valid), 32'd0);
      tick();
      applyStimulus(beat3(18'd20, 18'd7, 18'd30));
      checkOutput("t2_valid_early2", 32'(bus.out_valid), 32'd0);
      applyStimulus(beat3(18'd30, 18'd7, 18'd30));
      finishJob("t2", 32'h00000F5F);

      // T3: downstream stall with start pulses that must be ignored
      startJob(8'd1, 5'd0);
      applyStimulus(beat_all(18'd1));
      for (int i = 0; i < 5; i++) begin
         start    = 1'b1;
         num_pass = 8'd2;
         tick();
         checkOutput("t3_hold_data", bus.out_data, 32'h11111111);
         checkOutput("t3_hold_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("t3_hold_busy", 32'(busy), 32'd1);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      start         = 1'b0;
      checkOutput("t3_hs_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("t3_hs_busy", 32'(busy), 32'd0);
      checkOutput("t3_hs_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("t3_no_queue_busy", 32'(busy), 32'd0);

      // T4: accumulator saturation over 255 passes
      startJob(8'd255, 5'd20);
      for (int i = 0; i < 254; i++) begin
         applyStimulus(beat_all(18'h3FFFF));
      end
      checkOutput("t4_valid_early", 32'(bus.out_valid), 32'd0);
      applyStimulus(beat_all(18'h3FFFF));
      finishJob("t4", 32'hFFFFFFFF);

      // T5: asynchronous abort mid-job, then a clean job
      startJob(8'd4, 5'd0);
      applyStimulus(beat_all(18'd2));
      applyStimulus(beat_all(18'd2));
      rst_n = 1'b0;
      #2;
      checkOutput("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("t5_rst_busy", 32'(busy), 32'd0);
      checkOutput("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("t5_rst_out_data", bus.out_data, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      startJob(8'd1, 5'd0);
      applyStimulus(beat_all(18'd5));
      finishJob("t5", 32'h55555555);

      // T6: rounding mode, num_pass zero, oversized shift
      startJob(8'd1, 5'd2);
      applyStimulus(beat_all(18'd6));
      finishJob("t6_round", T6_EXP);

      startJob(8'd0, 5'd0);
      checkOutput("t6_np0_busy", 32'(busy), 32'd1);
      applyStimulus(beat_all(18'd7));
      finishJob("t6_np0", 32'h77777777);

      startJob(8'd1, 5'd24);
      applyStimulus(beat_all(18'h3FFFF));
      finishJob("t6_shift24", 32'h00000000);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
